// File: rtl/rip_branch_predictor_gshare_v2.sv
// Bimodal/gshare direction predictor with speculative global history,
// reset-time table initialisation and saturating performance counters.
module rip_branch_predictor_gshare_v2 #(
    parameter int INDEX_WIDTH = 10,
    parameter int HIST_WIDTH  = 10,
    parameter int CTR_WIDTH   = 2,
    parameter int MODE        = 1,
    parameter int PC_LSB      = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    output logic                   ready,
    input  logic                   lookup_valid,
    input  logic [31:0]            lookup_pc,
    output logic                   pred_valid,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_index,
    output logic [CTR_WIDTH-1:0]   pred_ctr,
    output logic [HIST_WIDTH-1:0]  pred_hist,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic [CTR_WIDTH-1:0]   upd_ctr,
    input  logic [HIST_WIDTH-1:0]  upd_hist,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict,
    output logic [31:0]            perf_lookups,
    output logic [31:0]            perf_mispredicts
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_MAX >> 1;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                 state;
    logic [INDEX_WIDTH-1:0] init_addr;
    logic [HIST_WIDTH-1:0]  ghr;
    logic [CTR_WIDTH-1:0]   pht [DEPTH];

    logic [INDEX_WIDTH-1:0] pc_bits;
    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic [INDEX_WIDTH-1:0] lk_index;
    logic                   lk_acc;
    logic                   upd_acc;
    logic                   recover;
    logic [CTR_WIDTH-1:0]   new_ctr;
    logic [HIST_WIDTH-1:0]  ghr_spec;
    logic [HIST_WIDTH-1:0]  ghr_recov;
    logic                   we;
    logic [INDEX_WIDTH-1:0] waddr;
    logic [CTR_WIDTH-1:0]   wdata;
    logic                   unused_pc;

    assign unused_pc = ^lookup_pc;
    assign pc_bits   = lookup_pc[PC_LSB+INDEX_WIDTH-1:PC_LSB];

    always_comb begin
        ghr_ext = '0;
        ghr_ext[HIST_WIDTH-1:0] = ghr;
    end

    assign lk_index = (MODE == 1) ? (pc_bits ^ ghr_ext) : pc_bits;
    assign lk_acc   = (state == S_RUN) & lookup_valid;
    assign upd_acc  = (state == S_RUN) & upd_valid;
    assign recover  = upd_acc & upd_mispredict;

    // Truncating casts drop the oldest bit; also correct for 1-bit history.
    assign ghr_spec  = HIST_WIDTH'({ghr, pred_taken});
    assign ghr_recov = HIST_WIDTH'({upd_hist, upd_taken});

    always_comb begin
        new_ctr = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != CTR_MAX) new_ctr = upd_ctr + CTR_WIDTH'(1);
        end else begin
            if (upd_ctr != '0) new_ctr = upd_ctr - CTR_WIDTH'(1);
        end
    end

    always_comb begin
        we    = 1'b0;
        waddr = init_addr;
        wdata = CTR_WNT;
        if (rstn) begin
            unique case (state)
                S_INIT: we = 1'b1;
                S_RUN: begin
                    we    = upd_valid;
                    waddr = upd_index;
                    wdata = new_ctr;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we) pht[waddr] <= wdata;
    end

    // The table read below sees the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= S_INIT;
            init_addr        <= '0;
            ready            <= 1'b0;
            ghr              <= '0;
            pred_valid       <= 1'b0;
            pred_taken       <= 1'b0;
            pred_index       <= '0;
            pred_ctr         <= '0;
            pred_hist        <= '0;
            perf_lookups     <= '0;
            perf_mispredicts <= '0;
        end else begin
            unique case (state)
                S_INIT: begin
                    init_addr <= init_addr + INDEX_WIDTH'(1);
                    if (init_addr == '1) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: ready <= 1'b1;
            endcase

            pred_valid <= lk_acc;
            if (lk_acc) begin
                pred_index <= lk_index;
                pred_ctr   <= pht[lk_index];
                pred_taken <= pht[lk_index][CTR_WIDTH-1];
                pred_hist  <= ghr;
            end

            if (MODE == 1) begin
                if (recover) ghr <= ghr_recov;
                else if (pred_valid) ghr <= ghr_spec;
            end

            if (lk_acc && perf_lookups != '1)
                perf_lookups <= perf_lookups + 32'd1;
            if (recover && perf_mispredicts != '1)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_rip_branch_predictor_gshare_v2.sv
// Directed scoreboard bench for the gshare predictor
// (depth 16, 4-bit history, 2-bit counters).
module tb_rip_branch_predictor_gshare_v2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ready;
    logic        lookup_valid = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic [3:0]  pred_index;
    logic [1:0]  pred_ctr;
    logic [3:0]  pred_hist;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_index = '0;
    logic [1:0]  upd_ctr = '0;
    logic [3:0]  upd_hist = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;

    rip_branch_predictor_gshare_v2 #(
        .INDEX_WIDTH(4),
        .HIST_WIDTH (4),
        .CTR_WIDTH  (2),
        .MODE       (1),
        .PC_LSB     (2)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ready           (ready),
        .lookup_valid    (lookup_valid),
        .lookup_pc       (lookup_pc),
        .pred_valid      (pred_valid),
        .pred_taken      (pred_taken),
        .pred_index      (pred_index),
        .pred_ctr        (pred_ctr),
        .pred_hist       (pred_hist),
        .upd_valid       (upd_valid),
        .upd_index       (upd_index),
        .upd_ctr         (upd_ctr),
        .upd_hist        (upd_hist),
        .upd_taken       (upd_taken),
        .upd_mispredict  (upd_mispredict),
        .perf_lookups    (perf_lookups),
        .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] idx;
        logic [1:0] ctr;
        logic       tk;
        logic [3:0] hist;
    } pred_t;

    pred_t      sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] m_pht [16];
    logic [3:0] m_ghr = '0;
    logic       m_pv = 1'b0;
    logic       m_pt = 1'b0;
    logic       m_ready = 1'b0;
    int         m_lookups = 0;
    int         m_misp = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    function automatic logic [31:0] pc_for(input logic [3:0] idx);
        return {26'd0, idx ^ m_ghr, 2'b00};
    endfunction

    // One clock: drive inputs, advance the reference model, sample.
    task automatic cyc(input logic lv, input logic [31:0] pc,
                       input logic uv, input logic [3:0] ui,
                       input logic [1:0] uc, input logic [3:0] uh,
                       input logic ut, input logic um);
        pred_t      e;
        logic [3:0] ng;
        e = '0;
        lookup_valid   = lv;
        lookup_pc      = pc;
        upd_valid      = uv;
        upd_index      = ui;
        upd_ctr        = uc;
        upd_hist       = uh;
        upd_taken      = ut;
        upd_mispredict = um;
        ng = m_ghr;
        if (m_ready) begin
            if (m_pv) ng = {m_ghr[2:0], m_pt};
            if (uv && um) begin
                ng = {uh[2:0], ut};
                m_misp++;
            end
            if (lv) begin
                e.idx  = pc[5:2] ^ m_ghr;
                e.ctr  = m_pht[e.idx];
                e.tk   = e.ctr[1];
                e.hist = m_ghr;
                sb.push_back(e);
                m_lookups++;
            end
            if (uv) m_pht[ui] = sat(uc, ut);
        end
        m_pv  = m_ready && lv;
        m_pt  = e.tk;
        m_ghr = ng;
        @(posedge clk);
        @(negedge clk);
        chk("pred_valid", pred_valid, m_pv);
    endtask

    task automatic idle();
        cyc(0, 32'h0, 0, 4'd0, 2'd0, 4'd0, 0, 0);
    endtask

    task automatic lk(input logic [31:0] pc);
        cyc(1, pc, 0, 4'd0, 2'd0, 4'd0, 0, 0);
    endtask

    task automatic up(input logic [3:0] ui, input logic [1:0] uc,
                      input logic [3:0] uh, input logic ut,
                      input logic um);
        cyc(0, 32'h0, 1, ui, uc, uh, ut, um);
    endtask

    task automatic do_reset(input logic busy);
        rstn = 1'b0;
        sb.delete();
        m_ready   = 1'b0;
        m_pv      = 1'b0;
        m_pt      = 1'b0;
        m_ghr     = '0;
        m_lookups = 0;
        m_misp    = 0;
        for (int i = 0; i < 16; i++) m_pht[i] = 2'b01;
        idle();
        idle();
        chk("rst_ready", ready, 0);
        chk("rst_taken", pred_taken, 0);
        chk("rst_index", pred_index, 0);
        chk("rst_ctr", pred_ctr, 0);
        chk("rst_hist", pred_hist, 0);
        chk("rst_perf_lk", perf_lookups, 0);
        chk("rst_perf_mp", perf_mispredicts, 0);
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("init_ready", ready, 0);
            if (busy) cyc(1, 32'h40, 1, 4'd0, 2'd3, 4'hF, 1, 1);
            else idle();
        end
        m_ready = 1'b1;
        chk("ready", ready, 1);
        chk("init_perf_lk", perf_lookups, 0);
        chk("init_perf_mp", perf_mispredicts, 0);
    endtask

    always @(negedge clk) begin
        if (rstn && pred_valid) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed pred_valid=1 expected none");
            end
            if (sb.size() != 0)
                chk("pred", {pred_index, pred_ctr, pred_taken, pred_hist},
                    sb.pop_front());
        end
    end

    initial begin
        @(negedge clk);
        do_reset(1);

        // first lookup after init sees weakly-not-taken
        lk(32'h40);
        chk("first_ctr", pred_ctr, 2'd1);
        chk("first_taken", pred_taken, 0);

        // counter update and saturation
        up(4'd0, 2'd1, 4'd0, 1, 0);
        lk(pc_for(4'd0));
        chk("inc_ctr", pred_ctr, 2'd2);
        chk("inc_taken", pred_taken, 1);
        idle();
        up(4'd0, 2'd3, 4'd0, 1, 0);
        lk(pc_for(4'd0));
        chk("sat_hi", pred_ctr, 2'd3);
        up(4'd0, 2'd0, 4'd0, 0, 0);
        lk(pc_for(4'd0));
        chk("sat_lo", pred_ctr, 2'd0);

        // recovery clears history, then speculative not-taken shifts
        up(4'd15, 2'd1, 4'd0, 0, 1);
        lk(32'h100);
        lk(32'h104);
        lk(32'h108);
        lk(32'h0);
        chk("hist_zero", pred_hist, 4'd0);
        chk("idx_zero", pred_index, 4'd0);
        up(4'd3, 2'd1, 4'b0101, 1, 1);
        lk(32'h0);
        chk("recov_hist", pred_hist, 4'b1011);
        chk("recov_idx", pred_index, 4'b1011);

        // recovery beats a simultaneous taken speculative shift
        lk(pc_for(4'd3));
        chk("t4_taken", pred_taken, 1);
        chk("t4_idx", pred_index, 4'd3);
        up(4'd9, 2'd1, 4'b0010, 0, 1);
        lk(32'h0);
        chk("t4_hist", pred_hist, 4'b0100);

        // read-first collision on index 5
        idle();
        cyc(1, pc_for(4'd5), 1, 4'd5, 2'd1, 4'd0, 1, 0);
        chk("coll_idx", pred_index, 4'd5);
        chk("coll_old", pred_ctr, 2'd1);
        lk(pc_for(4'd5));
        chk("coll_new", pred_ctr, 2'd2);

        // perf counters, then mid-run reset
        idle();
        chk("sb_drain1", sb.size(), 0);
        chk("perf_lk_a", perf_lookups, m_lookups);
        chk("perf_mp_a", perf_mispredicts, m_misp);
        do_reset(0);
        lk(32'h0);
        lk(32'h4);
        lk(32'h8);
        lk(32'hC);
        up(4'd6, 2'd3, 4'd0, 0, 1);
        lk(32'h10);
        lk(32'h14);
        lk(32'h18);
        up(4'd9, 2'd2, 4'hF, 1, 1);
        idle();
        chk("perf_lk_7", perf_lookups, 7);
        chk("perf_mp_2", perf_mispredicts, 2);
        chk("sb_drain2", sb.size(), 0);

        do_reset(1);
        lk(32'h0);
        chk("post_hist", pred_hist, 4'd0);
        chk("post_idx", pred_index, 4'd0);
        for (int i = 0; i < 16; i++) begin
            lk(32'(i) << 2);
            chk("post_wnt", pred_ctr, 2'b01);
        end
        idle();
        idle();
        chk("sb_drain3", sb.size(), 0);
        chk("perf_lk_end", perf_lookups, m_lookups);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
